dmem_ctrl: RTL

- Parametrised successor to the byte-addressed data memory.
- Byte-array storage, big-endian: byte at `addr` is the most significant. Same five access modes as before.
- Adds a valid/ready request/response handshake, configurable read latency, range checking and illegal-mode checking.
- Sits between the LSU/memory stage and the storage array; one access in flight at a time.

---
 rtl/dmem_pkg.sv | 52 +++++
 rtl/dmem_array.sv | 60 ++++++
 rtl/dmem_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: access-mode and
// FSM-state encodings, access-size lookup and big-endian load extension.
package dmem_pkg;

    typedef enum logic [2:0] {
        MODE_BYTE   = 3'b000,
        MODE_HALF   = 3'b001,
        MODE_WORD   = 3'b010,
        MODE_BYTE_U = 3'b011,
        MODE_HALF_U = 3'b100
    } mem_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Highest legal mode encoding; everything above is rejected.
    localparam logic [2:0] MODE_LAST = 3'b100;

    function automatic logic mode_legal(input logic [2:0] mode);
        return (mode <= MODE_LAST);
    endfunction

    // Number of bytes touched by an access of the given mode.
    function automatic logic [2:0] access_size(input logic [2:0] mode);
        logic [2:0] size;
        case (mode)
            MODE_BYTE, MODE_BYTE_U: size = 3'd1;
            MODE_HALF, MODE_HALF_U: size = 3'd2;
            MODE_WORD:              size = 3'd4;
            default:                size = 3'd1;
        endcase
        return size;
    endfunction

    // Extend a big-endian read window (byte at addr in raw[31:24]) to 32 bits.
    function automatic logic [31:0] load_extend(input logic [2:0] mode, input logic [31:0] raw);
        logic [31:0] ext;
        case (mode)
            MODE_BYTE:   ext = {{24{raw[31]}}, raw[31:24]};
            MODE_HALF:   ext = {{16{raw[31]}}, raw[31:16]};
            MODE_WORD:   ext = raw;
            MODE_BYTE_U: ext = {24'd0, raw[31:24]};
            MODE_HALF_U: ext = {16'd0, raw[31:16]};
            default:     ext = 32'd0;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-wide storage array, big-endian: synchronous 1/2/4-byte write and a
// combinational 4-byte read window starting at addr_i. Window bytes that fall
// past the end of the array read as zero. Contents are deliberately not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
)(
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [2:0]    size_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] idx_s [4];
    logic [31:0] wleft_s;

    // Byte addresses of the 4-byte window, one bit wider so they never wrap
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx_s[k] = {1'b0, addr_i} + (AW+1)'(k);
        end
    end

    // Left-align right-justified store data so byte k of the window is wleft_s[31-8k -: 8]
    always_comb begin
        wleft_s = wdata_i << {3'd4 - size_i, 3'b000};
    end

    // Big-endian write: most significant active byte lands at addr_i (storage is not reset)
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < 4; k++) begin
                if ((3'(k) < size_i) && (idx_s[k] < DEPTH_W)) begin
                    mem_q[idx_s[k][IW-1:0]] <= wleft_s[31-8*k -: 8];
                end
            end
        end
    end

    // Combinational read window; bytes beyond the array return zero
    always_comb begin
        rdata_o = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (idx_s[k] < DEPTH_W) begin
                rdata_o[31-8*k -: 8] = mem_q[idx_s[k][IW-1:0]];
            end else begin
                rdata_o[31-8*k -: 8] = 8'd0;
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request/response wrapper around a
// big-endian byte array. One access in flight; the response appears exactly
// RD_LAT edges after acceptance and is held until the consumer takes it.
// Stores commit on their acceptance edge. Range and illegal-mode errors are
// always checked; define DMEM_ALIGN_CHECK_EN to also reject misaligned
// HALF/HALF_U/WORD accesses.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int AW     = 32,
    parameter int RD_LAT = 1
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [2:0]    req_mode_i,
    input  logic [31:0]   req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o
);

    localparam int            CW       = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [CW-1:0] LAT_INIT = CW'(RD_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);

    dmem_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;

    logic [2:0]    size_s;
    logic [AW:0]   last_addr_s;
    logic          mode_err_s;
    logic          range_err_s;
    logic          align_err_s;
    logic          err_s;
    logic          accept_s;
    logic          wr_en_s;
    logic [31:0]   rd_window_s;
    logic [31:0]   rsp_rdata_d;
    logic          rsp_err_d;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (wr_en_s),
        .addr_i  (req_addr_i),
        .size_i  (size_s),
        .wdata_i (req_wdata_i),
        .rdata_o (rd_window_s)
    );

    // Request classification: size, last byte touched (AW+1 bits, no wrap) and error sources
    always_comb begin
        size_s      = access_size(req_mode_i);
        last_addr_s = {1'b0, req_addr_i} + (AW+1)'(size_s) - (AW+1)'(1);
        mode_err_s  = !mode_legal(req_mode_i);
        range_err_s = (last_addr_s >= DEPTH_W);
`ifdef DMEM_ALIGN_CHECK_EN
        if ((size_s == 3'd2) && req_addr_i[0]) begin
            align_err_s = 1'b1;
        end else if ((size_s == 3'd4) && (req_addr_i[1:0] != 2'b00)) begin
            align_err_s = 1'b1;
        end else begin
            align_err_s = 1'b0;
        end
`else
        align_err_s = 1'b0;
`endif
        err_s = mode_err_s | range_err_s | align_err_s;
    end

    // Acceptance and store commit: only in IDLE, and never for a rejected access
    always_comb begin
        accept_s = req_valid_i && req_ready_q;
        wr_en_s  = accept_s && req_we_i && !err_s;
    end

    // Response payload captured on the acceptance edge (stores and errors return zero)
    always_comb begin
        if (req_we_i || err_s) begin
            rsp_rdata_d = 32'd0;
        end else begin
            rsp_rdata_d = load_extend(req_mode_i, rd_window_s);
        end
        rsp_err_d = err_s;
    end

    // Control FSM with registered handshake outputs. WAIT spans the whole
    // latency (counter loaded with RD_LAT) so rsp_valid rises RD_LAT edges
    // after acceptance for every RD_LAT >= 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_q     <= ST_WAIT;
                        cnt_q       <= LAT_INIT;
                        req_ready_q <= 1'b0;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= rsp_err_d;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q     <= ST_RESP;
                        cnt_q       <= {CW{1'b0}};
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= {CW{1'b0}};
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                    rsp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
